// File: rtl/rr_buffer_pkg.sv
// Shared constants and helpers for the round-robin channel buffer.
package rr_buffer_pkg;

  // Ceiling log2 usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  localparam int DATA_W_DEF = 35;
  localparam int DEPTH_DEF  = 8;
  localparam int PTR_W_DEF  = clog2(DEPTH_DEF);
  localparam int CNT_W_DEF  = clog2(DEPTH_DEF + 1);

endpackage

// File: rtl/rr_buffer_fifo.sv
// First-word-fall-through FIFO with occupancy and almost-full status.
// A push while full is dropped, even if a pop happens in the same cycle.
module rr_buffer_fifo
  import rr_buffer_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int AFULL_LVL = 6,
  localparam int PTR_W     = clog2(DEPTH),
  localparam int CNT_W     = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && out_valid;
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CNT_W'(AFULL_LVL));

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO at once.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q = 0 already marks every entry as invalid.
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rr_buffer.sv
// Round-robin arbiter merging NUM_CH valid/ready producers into one FIFO.
module rr_buffer
  import rr_buffer_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int AFULL_LVL = 6,
  localparam int CNT_W     = clog2(DEPTH + 1),
  localparam int GNT_W     = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         count,
  output logic                     almost_full
);

  logic [GNT_W-1:0]  last_grant_q, last_grant_d;
  logic [GNT_W-1:0]  grant_idx;
  logic [GNT_W-1:0]  cand;
  logic              grant_found;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;

  // Scan upward from the channel after the last winner; first valid one wins.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    in_ready    = '0;
    if (reset && !full) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = GNT_W'((int'(last_grant_q) + k) % NUM_CH);
        if (!grant_found && in_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
      if (grant_found) in_ready[grant_idx] = 1'b1;
    end
  end

  assign push      = |in_ready;
  assign push_data = in_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign pop       = out_valid && out_ready;

  // The round-robin pointer moves only when a word is actually accepted.
  always_comb begin
    last_grant_d = last_grant_q;
    if (push) last_grant_d = grant_idx;
  end

  // Round-robin pointer register; after reset channel 0 has top priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant_q <= GNT_W'(NUM_CH - 1);
    else        last_grant_q <= last_grant_d;
  end

  rr_buffer_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_data),
    .full        (full),
    .pop         (pop),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

endmodule

// File: tb/tb_rr_buffer.sv
// Scoreboard bench for rr_buffer: randomized producers and consumer,
// behavioural model of arbitration and FIFO order kept as a queue.
module tb_rr_buffer;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 35;
  localparam int DEPTH     = 8;
  localparam int AFULL_LVL = 6;
  localparam int CNT_W     = 4;

  logic                     clk;
  logic                     reset;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready;
  logic [CNT_W-1:0]         count;
  logic                     almost_full;

  rr_buffer #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus controls, written by the main sequence.
  logic [NUM_CH-1:0] mask      = '0;
  int                valid_pct = 100;
  int                drop_pct  = 0;
  int                ordy_pct  = 0;
  int unsigned       seq       = 0;

  // Producers: hold a word until granted, then offer a fresh one or go idle.
  initial begin
    logic [NUM_CH-1:0] gr;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      gr = in_ready;
      @(posedge clk);
      #1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (!mask[ch]) begin
          in_valid[ch] = 1'b0;
        end else if (!in_valid[ch] || gr[ch]) begin
          if ($urandom_range(99) < valid_pct) begin
            in_valid[ch] = 1'b1;
            in_data[ch*DATA_W +: DATA_W] = {3'(ch), 32'(seq)};
            seq++;
          end else begin
            in_valid[ch] = 1'b0;
          end
        end else if ($urandom_range(99) < drop_pct) begin
          in_valid[ch] = 1'b0;
        end
      end
      out_ready = ($urandom_range(99) < ordy_pct);
    end
  end

  // Reference arbitration: nearest valid channel after the last winner, circularly.
  function automatic int expected_grant(input logic [NUM_CH-1:0] v, input int lg, input bit is_full);
    if (is_full) return -1;
    for (int d = 1; d <= NUM_CH; d++) begin
      if (v[(lg + d) % NUM_CH]) return (lg + d) % NUM_CH;
    end
    return -1;
  endfunction

  // Monitor / scoreboard: compares outputs to the model, then advances it.
  logic [DATA_W-1:0] sb_q[$];
  int                m_lg = NUM_CH - 1;

  initial begin
    int sz;
    int eg;
    logic [NUM_CH-1:0] er;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_almost_full", almost_full, 0);
        sb_q.delete();
        m_lg = NUM_CH - 1;
      end else begin
        sz = sb_q.size();
        check("count", count, sz);
        check("out_valid", out_valid, sz != 0);
        check("almost_full", almost_full, sz >= AFULL_LVL);
        eg = expected_grant(in_valid, m_lg, sz == DEPTH);
        er = (eg < 0) ? '0 : NUM_CH'(1) << eg;
        check("in_ready", in_ready, er);
        if (sz != 0 && out_ready) begin
          check("out_data", out_data, sb_q[0]);
          void'(sb_q.pop_front());
        end
        if (eg >= 0) begin
          sb_q.push_back(in_data[eg*DATA_W +: DATA_W]);
          m_lg = eg;
        end
      end
    end
  end

  task automatic set_mode(input logic [NUM_CH-1:0] m, input int vp, input int dp, input int op);
    mask      = m;
    valid_pct = vp;
    drop_pct  = dp;
    ordy_pct  = op;
  endtask

  initial begin
    int i;
    reset = 1'b0;
    set_mode('0, 100, 0, 0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;

    // Fairness: all channels valid, consumer always ready.
    set_mode(4'b1111, 100, 0, 100);
    repeat (20) @(posedge clk);
    #2 check("fair_count_steady", count, 1);

    // Drain, then fill from channel 2 with the consumer stalled.
    set_mode('0, 100, 0, 100);
    repeat (4) @(posedge clk);
    set_mode(4'b0100, 100, 0, 0);
    repeat (14) @(posedge clk);
    #2;
    check("fill_count_full", count, DEPTH);
    check("fill_almost_full", almost_full, 1);
    check("fill_ready_blocked", in_ready[2], 0);

    // Drain after full; model checks that full plus pop never pushes.
    set_mode(4'b0100, 100, 0, 100);
    repeat (12) @(posedge clk);

    // Sparse: only channels 1 and 3.
    set_mode(4'b1010, 100, 0, 50);
    repeat (30) @(posedge clk);

    // Mid-operation reset with five words stored.
    set_mode('0, 100, 0, 100);
    repeat (10) @(posedge clk);
    set_mode(4'b0001, 100, 0, 0);
    i = 0;
    @(negedge clk);
    while (i < 30 && count != 4) begin
      @(negedge clk);
      i++;
    end
    check("pre_reset_reached", count, 4);
    @(posedge clk);
    #2 check("pre_reset_count", count, 5);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_out_valid", out_valid, 0);
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", out_valid, 1);
    check("post_rst_count", count, 1);

    // Randomized traffic.
    for (int blk = 0; blk < 40; blk++) begin
      set_mode(NUM_CH'($urandom_range(15)), $urandom_range(20, 100), 10, $urandom_range(10, 90));
      repeat (50) @(posedge clk);
    end

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_buffer.md
Name: rr_buffer

Overview:
- Parametrised successor to the four-input buffer: arbitrates NUM_CH producer channels into one FIFO and drains it to a single consumer.
- Round-robin arbitration is fair, with explicit valid/ready on every channel and on the output.
- Exports occupancy and almost-full status.
- Sits between the channel producers and the next pipeline stage, which supplies out_ready.

Parameters:
- NUM_CH, 4, number of input channels (2..16)
- DATA_W, 35, data word width
- DEPTH, 8, FIFO entries (power of two, >= 2)
- AFULL_LVL, 6, occupancy at or above which almost_full asserts (1..DEPTH)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  NUM_CH  per-channel data-valid
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_ready  out  NUM_CH  per-channel accept strobe, at most one bit set
- out_valid  out  1  FIFO head valid
- out_data  out  DATA_W  FIFO head word
- out_ready  in  1  consumer accepts head this cycle
- count  out  $clog2(DEPTH+1)  current occupancy
- almost_full  out  1  count >= AFULL_LVL

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, count=0, out_valid=0, almost_full=0, read/write pointers 0, round-robin pointer last_grant=NUM_CH-1. While reset is low, in_ready=0. out_data is don't-care while out_valid=0.
- Arbitration (combinational from in_valid, last_grant and full):
  - If full, in_ready is all zeros.
  - Otherwise, grant the first channel with in_valid=1, scanning from last_grant+1 upward with wrap modulo NUM_CH. in_ready is one-hot on that channel.
  - If no channel is valid, in_ready=0.
- Push: occurs when any in_ready bit is set. The selected channel's word is written at wr_ptr, wr_ptr increments (wraps at DEPTH), and last_grant takes the winner's index. last_grant holds when there is no push.
- Pop: occurs when out_valid && out_ready. rd_ptr increments with wrap.
- Output is first-word-fall-through:
  - out_data reads the storage array at rd_ptr combinationally.
  - out_valid = (count != 0).
  - A word pushed into an empty FIFO appears on out_data/out_valid the cycle after the push (latency 1).
- Occupancy: count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
- Full: count == DEPTH blocks push even if a pop happens in the same cycle (no pass-through when full). The pop still proceeds, so the next cycle accepts again.
- Empty: out_valid=0; out_ready is ignored, no pointer movement, count never underflows.
- Simultaneous push and pop while count=1: the head pops, the new word becomes head the next cycle, count stays 1.
- almost_full is registered-equivalent: it is derived from the registered count and updates the same cycle count changes.
- Producers hold in_valid/in_data stable until they see their in_ready. A channel that drops in_valid without a grant loses no fairness slot.
- Reset asserted mid-operation: all contents are discarded immediately and no partially written word survives. The first post-reset grant goes to the lowest-index valid channel.

Decomposition:
- Package rr_buffer_pkg holds:
  - function clog2
  - localparams for pointer width (clog2(DEPTH)) and count width (clog2(DEPTH+1))
  - the default DATA_W=35
- Sub-module rr_buffer_fifo holds storage, pointers, count, out_valid/out_data and almost_full. It exposes push, push_data, full, pop.
- Top level rr_buffer holds the round-robin arbiter, input data select and last_grant register, and instantiates rr_buffer_fifo.

Test Plan:
- Reset then idle: reset low 3 cycles, all in_valid=0 -> in_ready=0, out_valid=0, count=0, almost_full=0 throughout.
- Fairness: all 4 channels valid continuously, out_ready=1 -> grants cycle ch0, ch1, ch2, ch3, ch0; out_data order matches, count stays at 1.
- Fill to full: ch2 valid with data 0..9, out_ready=0 -> 8 words accepted. almost_full rises when count reaches 6. in_ready[2]=0 once count=8.
- Drain after full: out_ready=1 for 8 cycles -> out_data 0..7 in order. Full plus pop never pushes in the same cycle, and the next pending word (8) is accepted the cycle after the first pop.
- Sparse valid: only ch1 and ch3 valid, last_grant=1 -> grant ch3, then ch1, alternating; ch0 and ch2 never receive in_ready.
- Mid-operation reset: count=5, assert reset for 1 cycle -> count=0 and out_valid=0 immediately. After release with ch0 valid, word accepted and visible the next cycle.
